// File: rtl/weight_glb_pkg.sv
// Shared definitions for the weight GLB sender and the router cluster top:
// default stream widths, sender FSM encoding and the read-credit helper.
package weight_glb_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 13;
    localparam int DEF_LEN_W  = 9;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_SEND_ADDR = 2'd1;
    localparam logic [1:0] ST_SEND_DATA = 2'd2;
    localparam logic [1:0] ST_FINISH    = 2'd3;

    // A pop this cycle frees a slot, which is what keeps the stream bubble-free.
    function automatic logic slot_free(input logic [1:0] count,
                                       input logic       pend,
                                       input logic       pop);
        logic [2:0] used;
        used = {1'b0, count} + {2'b00, pend} - {2'b00, pop};
        return (used < 3'd2);
    endfunction

endpackage

// File: rtl/weight_glb_sender_stream_fifo2.sv
// Two-entry FIFO holding words returned by a 1-cycle-latency memory until the
// router accepts them. The caller guarantees no push when full, no pop when empty.
module stream_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [1:0]   count_o,
    output logic [W-1:0] head_o
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;
    logic [1:0]   count_d;

    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                mem_q[gi] <= '0;
            end else if (push_i && (wr_ptr_q == gi[0])) begin
                mem_q[gi] <= wdata_i;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) wr_ptr_q <= ~wr_ptr_q;
            if (pop_i)  rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/weight_glb_sender.sv
// Streams one CSC weight block (address words, then data words) from the GLB
// address/data memories into the weight router's GLB inputs with valid/ready.
module weight_glb_sender
    import weight_glb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int AMEM_AW = 7,
    parameter int DMEM_AW = 9,
    parameter int LEN_W   = DEF_LEN_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [AMEM_AW-1:0] addr_base,
    input  logic [LEN_W-1:0]   addr_len,
    input  logic [DMEM_AW-1:0] data_base,
    input  logic [LEN_W-1:0]   data_len,
    output logic               busy,
    output logic               done,
    output logic               amem_ren,
    output logic [AMEM_AW-1:0] amem_raddr,
    input  logic [ADDR_W-1:0]  amem_rdata,
    output logic               dmem_ren,
    output logic [DMEM_AW-1:0] dmem_raddr,
    input  logic [DATA_W-1:0]  dmem_rdata,
    output logic               GLB_address_in_valid,
    output logic [ADDR_W-1:0]  GLB_address_in,
    input  logic               GLB_address_in_ready,
    output logic               GLB_data_in_valid,
    output logic [DATA_W-1:0]  GLB_data_in,
    input  logic               GLB_data_in_ready
);

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    logic [1:0]         state_q, state_d;
    logic [AMEM_AW-1:0] a_base_q, a_base_d;
    logic [DMEM_AW-1:0] d_base_q, d_base_d;
    logic [LEN_W-1:0]   a_len_q, a_len_d;
    logic [LEN_W-1:0]   d_len_q, d_len_d;
    logic [LEN_W-1:0]   a_iss_q, a_iss_d;
    logic [LEN_W-1:0]   d_iss_q, d_iss_d;
    logic [LEN_W-1:0]   a_sent_q, a_sent_d;
    logic [LEN_W-1:0]   d_sent_q, d_sent_d;
    logic               zero_blk_q, zero_blk_d;
    logic               a_pend_q;
    logic               d_pend_q;

    logic               in_addr;
    logic               in_data;
    logic [1:0]         a_count;
    logic [1:0]         d_count;
    logic [ADDR_W-1:0]  a_head;
    logic [DATA_W-1:0]  d_head;
    logic               a_pop;
    logic               d_pop;
    logic               a_last;
    logic               d_last;

    assign in_addr = (state_q == ST_SEND_ADDR);
    assign in_data = (state_q == ST_SEND_DATA);

    // Valids are gated by phase so the two streams can never overlap.
    assign GLB_address_in_valid = in_addr && (a_count != 2'd0);
    assign GLB_data_in_valid    = in_data && (d_count != 2'd0);
    assign GLB_address_in       = a_head;
    assign GLB_data_in          = d_head;

    assign a_pop = GLB_address_in_valid && GLB_address_in_ready;
    assign d_pop = GLB_data_in_valid && GLB_data_in_ready;

    assign a_last = a_pop && ((a_sent_q + LEN_ONE) == a_len_q);
    assign d_last = d_pop && ((d_sent_q + LEN_ONE) == d_len_q);

    assign amem_ren   = in_addr && (a_iss_q < a_len_q) && slot_free(a_count, a_pend_q, a_pop);
    assign dmem_ren   = in_data && (d_iss_q < d_len_q) && slot_free(d_count, d_pend_q, d_pop);
    assign amem_raddr = a_base_q + AMEM_AW'(a_iss_q);
    assign dmem_raddr = d_base_q + DMEM_AW'(d_iss_q);

    // An empty block has no streaming phase, so busy covers its FINISH cycle instead.
    assign busy = in_addr || in_data || ((state_q == ST_FINISH) && zero_blk_q);
    assign done = (state_q == ST_FINISH);

    always_comb begin
        state_d    = state_q;
        a_base_d   = a_base_q;
        d_base_d   = d_base_q;
        a_len_d    = a_len_q;
        d_len_d    = d_len_q;
        zero_blk_d = zero_blk_q;
        a_iss_d    = a_iss_q + (amem_ren ? LEN_ONE : '0);
        d_iss_d    = d_iss_q + (dmem_ren ? LEN_ONE : '0);
        a_sent_d   = a_sent_q + (a_pop ? LEN_ONE : '0);
        d_sent_d   = d_sent_q + (d_pop ? LEN_ONE : '0);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_base_d   = addr_base;
                    d_base_d   = data_base;
                    a_len_d    = addr_len;
                    d_len_d    = data_len;
                    a_iss_d    = '0;
                    d_iss_d    = '0;
                    a_sent_d   = '0;
                    d_sent_d   = '0;
                    zero_blk_d = (addr_len == '0) && (data_len == '0);
                    if (addr_len != '0)      state_d = ST_SEND_ADDR;
                    else if (data_len != '0) state_d = ST_SEND_DATA;
                    else                     state_d = ST_FINISH;
                end
            end
            ST_SEND_ADDR: begin
                if (a_last) state_d = (d_len_q != '0) ? ST_SEND_DATA : ST_FINISH;
            end
            ST_SEND_DATA: begin
                if (d_last) state_d = ST_FINISH;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            a_base_q   <= '0;
            d_base_q   <= '0;
            a_len_q    <= '0;
            d_len_q    <= '0;
            a_iss_q    <= '0;
            d_iss_q    <= '0;
            a_sent_q   <= '0;
            d_sent_q   <= '0;
            zero_blk_q <= 1'b0;
            a_pend_q   <= 1'b0;
            d_pend_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_base_q   <= a_base_d;
            d_base_q   <= d_base_d;
            a_len_q    <= a_len_d;
            d_len_q    <= d_len_d;
            a_iss_q    <= a_iss_d;
            d_iss_q    <= d_iss_d;
            a_sent_q   <= a_sent_d;
            d_sent_q   <= d_sent_d;
            zero_blk_q <= zero_blk_d;
            a_pend_q   <= amem_ren;
            d_pend_q   <= dmem_ren;
        end
    end

    // A read issued last cycle returns now and lands in its stream's FIFO.
    stream_fifo2 #(.W(ADDR_W)) u_afifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (a_pend_q),
        .wdata_i (amem_rdata),
        .pop_i   (a_pop),
        .count_o (a_count),
        .head_o  (a_head)
    );

    stream_fifo2 #(.W(DATA_W)) u_dfifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (d_pend_q),
        .wdata_i (dmem_rdata),
        .pop_i   (d_pop),
        .count_o (d_count),
        .head_o  (d_head)
    );

endmodule

// File: tb/tb_weight_glb_sender.sv
// Directed bench for weight_glb_sender: memory models with 1-cycle read latency,
// per-scenario tasks with hand-computed expectations.
module tb_weight_glb_sender;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 13;
    localparam int AMEM_AW = 7;
    localparam int DMEM_AW = 9;
    localparam int LEN_W   = 9;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [AMEM_AW-1:0] addr_base = '0;
    logic [LEN_W-1:0]   addr_len = '0;
    logic [DMEM_AW-1:0] data_base = '0;
    logic [LEN_W-1:0]   data_len = '0;
    logic               busy, done;
    logic               amem_ren, dmem_ren;
    logic [AMEM_AW-1:0] amem_raddr;
    logic [DMEM_AW-1:0] dmem_raddr;
    logic [ADDR_W-1:0]  amem_rdata = '0;
    logic [DATA_W-1:0]  dmem_rdata = '0;
    logic               a_valid, d_valid;
    logic [ADDR_W-1:0]  a_word;
    logic [DATA_W-1:0]  d_word;
    logic               a_rdy = 1'b1;
    logic               d_rdy = 1'b1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    weight_glb_sender #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .AMEM_AW(AMEM_AW), .DMEM_AW(DMEM_AW), .LEN_W(LEN_W)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .start                (start),
        .addr_base            (addr_base),
        .addr_len             (addr_len),
        .data_base            (data_base),
        .data_len             (data_len),
        .busy                 (busy),
        .done                 (done),
        .amem_ren             (amem_ren),
        .amem_raddr           (amem_raddr),
        .amem_rdata           (amem_rdata),
        .dmem_ren             (dmem_ren),
        .dmem_raddr           (dmem_raddr),
        .dmem_rdata           (dmem_rdata),
        .GLB_address_in_valid (a_valid),
        .GLB_address_in       (a_word),
        .GLB_address_in_ready (a_rdy),
        .GLB_data_in_valid    (d_valid),
        .GLB_data_in          (d_word),
        .GLB_data_in_ready    (d_rdy)
    );

    // Memory contents are simple functions of the entry index.
    function automatic logic [ADDR_W-1:0] aval(input int e);
        return ADDR_W'(e + 100);
    endfunction

    function automatic logic [DATA_W-1:0] dval(input int e);
        return DATA_W'(e * 9 + 5);
    endfunction

    logic [ADDR_W-1:0] amem [128];
    logic [DATA_W-1:0] dmem [512];

    initial begin
        for (int i = 0; i < 128; i++) amem[i] = aval(i);
        for (int i = 0; i < 512; i++) dmem[i] = dval(i);
    end

    always @(posedge clk) begin
        if (amem_ren) amem_rdata <= amem[amem_raddr];
        if (dmem_ren) dmem_rdata <= dmem[dmem_raddr];
    end

    // Observations of the most recent block.
    logic [ADDR_W-1:0] got_a [$];
    logic [DATA_W-1:0] got_d [$];
    int got_araddr [$];
    int done_cnt, busy_cnt, done_cyc, last_d_cyc, first_a_cyc, first_d_cyc;
    int a_reads, d_reads, max_a_out, max_d_out, stall_viol, overlap_viol;
    bit finished;

    // mode 0: both readys high; mode 1: address ready low for cycles 0..3, data ready 1010...
    // stop_d >= 0 ends the run right after that many data handshakes.
    task automatic drive_block(input int abase, input int alen, input int dbase, input int dlen,
                               input int mode, input int stop_d, input bit restart);
        int cyc;
        int a_hs;
        int d_hs;
        bit prev_a_stall;
        bit prev_d_stall;
        logic [ADDR_W-1:0] prev_a_word;
        logic [DATA_W-1:0] prev_d_word;
        got_a.delete(); got_d.delete(); got_araddr.delete();
        done_cnt = 0; busy_cnt = 0; done_cyc = -1; last_d_cyc = -1;
        first_a_cyc = -1; first_d_cyc = -1; a_reads = 0; d_reads = 0;
        max_a_out = 0; max_d_out = 0; stall_viol = 0; overlap_viol = 0; finished = 0;
        a_hs = 0; d_hs = 0; prev_a_stall = 0; prev_d_stall = 0;
        prev_a_word = '0; prev_d_word = '0;
        a_rdy = 1'b1; d_rdy = 1'b1;
        addr_base = AMEM_AW'(abase); addr_len = LEN_W'(alen);
        data_base = DMEM_AW'(dbase); data_len = LEN_W'(dlen);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (cyc < 400) begin
            if (stop_d >= 0 && got_d.size() == stop_d) break;
            if (mode == 1) begin
                a_rdy = (cyc >= 4);
                d_rdy = ((cyc % 2) == 0);
            end else begin
                a_rdy = 1'b1;
                d_rdy = 1'b1;
            end
            start = 1'b0;
            if (restart && cyc == 3) begin
                start = 1'b1;
                addr_base = AMEM_AW'(abase + 7); addr_len = LEN_W'(alen + 1);
                data_base = DMEM_AW'(dbase + 7); data_len = LEN_W'(dlen + 1);
            end
            #1;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (!finished) begin
                    done_cyc = cyc;
                    finished = 1;
                end
            end
            if (amem_ren) begin
                a_reads++;
                got_araddr.push_back(int'(amem_raddr));
            end
            if (dmem_ren) d_reads++;
            if (prev_a_stall && (!a_valid || a_word !== prev_a_word)) stall_viol++;
            if (prev_d_stall && (!d_valid || d_word !== prev_d_word)) stall_viol++;
            prev_a_stall = a_valid && !a_rdy;
            prev_d_stall = d_valid && !d_rdy;
            prev_a_word  = a_word;
            prev_d_word  = d_word;
            if (a_valid && d_valid) overlap_viol++;
            if (a_valid && first_d_cyc >= 0) overlap_viol++;
            if (a_valid && first_a_cyc < 0) first_a_cyc = cyc;
            if (d_valid && first_d_cyc < 0) first_d_cyc = cyc;
            if (a_valid && a_rdy) begin
                got_a.push_back(a_word);
                a_hs++;
            end
            if (d_valid && d_rdy) begin
                got_d.push_back(d_word);
                d_hs++;
                last_d_cyc = cyc;
            end
            if (a_reads - a_hs > max_a_out) max_a_out = a_reads - a_hs;
            if (d_reads - d_hs > max_d_out) max_d_out = d_reads - d_hs;
            @(negedge clk);
            cyc++;
            if (finished && cyc > done_cyc + 4) break;
        end
        start = 1'b0;
        a_rdy = 1'b1;
        d_rdy = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if ({busy, done, amem_ren, dmem_ren, a_valid, d_valid} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b, want 000000", {busy, done, amem_ren, dmem_ren, a_valid, d_valid});
        end
        n_cmp++;
        if (amem_raddr !== '0 || dmem_raddr !== '0) begin
            n_err++;
            $display("FAIL reset_raddr: got a=%0d d=%0d, want 0/0", amem_raddr, dmem_raddr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        $display("test_reset: done");
    endtask

    task automatic test_basic();
        drive_block(10, 3, 20, 5, 0, -1, 0);
        n_cmp++;
        if (got_a.size() !== 3 || got_d.size() !== 5) begin
            n_err++;
            $display("FAIL basic_count: got a=%0d d=%0d words, want 3/5", got_a.size(), got_d.size());
        end
        for (int i = 0; i < 3 && i < got_a.size(); i++) begin
            n_cmp++;
            if (got_a[i] !== aval(10 + i)) begin
                n_err++;
                $display("FAIL basic_addr[%0d]: got %0d, want %0d", i, got_a[i], aval(10 + i));
            end
        end
        for (int i = 0; i < 5 && i < got_d.size(); i++) begin
            n_cmp++;
            if (got_d[i] !== dval(20 + i)) begin
                n_err++;
                $display("FAIL basic_data[%0d]: got %0d, want %0d", i, got_d[i], dval(20 + i));
            end
        end
        n_cmp++;
        if (first_a_cyc !== 2 || first_d_cyc !== 7) begin
            n_err++;
            $display("FAIL basic_latency: got first a=%0d d=%0d, want 2/7", first_a_cyc, first_d_cyc);
        end
        n_cmp++;
        if (last_d_cyc !== 11 || done_cyc !== 12) begin
            n_err++;
            $display("FAIL basic_done_time: got last_d=%0d done=%0d, want 11/12", last_d_cyc, done_cyc);
        end
        n_cmp++;
        if (done_cnt !== 1) begin
            n_err++;
            $display("FAIL basic_done_cnt: got %0d, want 1", done_cnt);
        end
        n_cmp++;
        if (busy_cnt !== 12) begin
            n_err++;
            $display("FAIL basic_busy: got %0d busy cycles, want 12", busy_cnt);
        end
        n_cmp++;
        if (overlap_viol !== 0) begin
            n_err++;
            $display("FAIL basic_overlap: got %0d, want 0", overlap_viol);
        end
        $display("test_basic: a=%0d d=%0d words done_cyc=%0d", got_a.size(), got_d.size(), done_cyc);
    endtask

    task automatic test_backpressure();
        drive_block(10, 3, 20, 5, 1, -1, 0);
        n_cmp++;
        if (got_a.size() !== 3 || got_d.size() !== 5) begin
            n_err++;
            $display("FAIL bp_count: got a=%0d d=%0d words, want 3/5", got_a.size(), got_d.size());
        end
        for (int i = 0; i < 3 && i < got_a.size(); i++) begin
            n_cmp++;
            if (got_a[i] !== aval(10 + i)) begin
                n_err++;
                $display("FAIL bp_addr[%0d]: got %0d, want %0d", i, got_a[i], aval(10 + i));
            end
        end
        for (int i = 0; i < 5 && i < got_d.size(); i++) begin
            n_cmp++;
            if (got_d[i] !== dval(20 + i)) begin
                n_err++;
                $display("FAIL bp_data[%0d]: got %0d, want %0d", i, got_d[i], dval(20 + i));
            end
        end
        n_cmp++;
        if (stall_viol !== 0) begin
            n_err++;
            $display("FAIL bp_stable: got %0d unstable stalls, want 0", stall_viol);
        end
        n_cmp++;
        if (max_a_out !== 2) begin
            n_err++;
            $display("FAIL bp_addr_outstanding: got max %0d, want 2", max_a_out);
        end
        n_cmp++;
        if (max_d_out > 2) begin
            n_err++;
            $display("FAIL bp_data_outstanding: got max %0d, want <= 2", max_d_out);
        end
        n_cmp++;
        if (a_reads !== 3 || d_reads !== 5) begin
            n_err++;
            $display("FAIL bp_reads: got a=%0d d=%0d reads, want 3/5", a_reads, d_reads);
        end
        n_cmp++;
        if (done_cnt !== 1 || overlap_viol !== 0) begin
            n_err++;
            $display("FAIL bp_done_overlap: got done=%0d overlap=%0d, want 1/0", done_cnt, overlap_viol);
        end
        $display("test_backpressure: a=%0d d=%0d words done_cyc=%0d", got_a.size(), got_d.size(), done_cyc);
    endtask

    task automatic test_zero_len();
        drive_block(5, 0, 5, 0, 0, -1, 0);
        n_cmp++;
        if (done_cnt !== 1 || done_cyc !== 0) begin
            n_err++;
            $display("FAIL zero_done: got cnt=%0d cyc=%0d, want 1/0", done_cnt, done_cyc);
        end
        n_cmp++;
        if (busy_cnt !== 1) begin
            n_err++;
            $display("FAIL zero_busy: got %0d busy cycles, want 1", busy_cnt);
        end
        n_cmp++;
        if (first_a_cyc !== -1 || first_d_cyc !== -1) begin
            n_err++;
            $display("FAIL zero_valid: got first a=%0d d=%0d, want -1/-1", first_a_cyc, first_d_cyc);
        end
        n_cmp++;
        if (a_reads !== 0 || d_reads !== 0) begin
            n_err++;
            $display("FAIL zero_reads: got a=%0d d=%0d, want 0/0", a_reads, d_reads);
        end
        $display("test_zero_len: done_cyc=%0d busy_cycles=%0d", done_cyc, busy_cnt);
    endtask

    task automatic test_wrap();
        int exp_ptr [4];
        exp_ptr = '{126, 127, 0, 1};
        drive_block(126, 4, 300, 2, 0, -1, 0);
        n_cmp++;
        if (got_araddr.size() !== 4 || got_a.size() !== 4 || got_d.size() !== 2) begin
            n_err++;
            $display("FAIL wrap_count: got reads=%0d a=%0d d=%0d, want 4/4/2",
                     got_araddr.size(), got_a.size(), got_d.size());
        end
        for (int i = 0; i < 4 && i < got_araddr.size(); i++) begin
            n_cmp++;
            if (got_araddr[i] !== exp_ptr[i]) begin
                n_err++;
                $display("FAIL wrap_raddr[%0d]: got %0d, want %0d", i, got_araddr[i], exp_ptr[i]);
            end
        end
        for (int i = 0; i < 4 && i < got_a.size(); i++) begin
            n_cmp++;
            if (got_a[i] !== aval(exp_ptr[i])) begin
                n_err++;
                $display("FAIL wrap_addr[%0d]: got %0d, want %0d", i, got_a[i], aval(exp_ptr[i]));
            end
        end
        for (int i = 0; i < 2 && i < got_d.size(); i++) begin
            n_cmp++;
            if (got_d[i] !== dval(300 + i)) begin
                n_err++;
                $display("FAIL wrap_data[%0d]: got %0d, want %0d", i, got_d[i], dval(300 + i));
            end
        end
        n_cmp++;
        if (done_cnt !== 1) begin
            n_err++;
            $display("FAIL wrap_done: got %0d, want 1", done_cnt);
        end
        $display("test_wrap: reads=%0d done_cyc=%0d", got_araddr.size(), done_cyc);
    endtask

    task automatic test_reset_mid();
        int late_done;
        int late_valid;
        drive_block(10, 3, 20, 5, 0, 2, 0);
        n_cmp++;
        if (got_d.size() !== 2 || !busy) begin
            n_err++;
            $display("FAIL rmid_setup: got %0d data words busy=%b, want 2/1", got_d.size(), busy);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, amem_ren, dmem_ren, a_valid, d_valid} !== 6'b0) begin
            n_err++;
            $display("FAIL rmid_outputs: got %b, want 000000", {busy, done, amem_ren, dmem_ren, a_valid, d_valid});
        end
        n_cmp++;
        if (amem_raddr !== '0 || dmem_raddr !== '0) begin
            n_err++;
            $display("FAIL rmid_raddr: got a=%0d d=%0d, want 0/0", amem_raddr, dmem_raddr);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        late_done = 0;
        late_valid = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            if (done) late_done++;
            if (a_valid || d_valid || busy) late_valid++;
        end
        n_cmp++;
        if (late_done !== 0 || late_valid !== 0) begin
            n_err++;
            $display("FAIL rmid_quiet: got done=%0d active=%0d, want 0/0", late_done, late_valid);
        end
        @(negedge clk);
        drive_block(40, 2, 60, 3, 0, -1, 0);
        n_cmp++;
        if (got_a.size() !== 2 || got_d.size() !== 3) begin
            n_err++;
            $display("FAIL rmid_next_count: got a=%0d d=%0d, want 2/3", got_a.size(), got_d.size());
        end
        for (int i = 0; i < 2 && i < got_a.size(); i++) begin
            n_cmp++;
            if (got_a[i] !== aval(40 + i)) begin
                n_err++;
                $display("FAIL rmid_next_addr[%0d]: got %0d, want %0d", i, got_a[i], aval(40 + i));
            end
        end
        for (int i = 0; i < 3 && i < got_d.size(); i++) begin
            n_cmp++;
            if (got_d[i] !== dval(60 + i)) begin
                n_err++;
                $display("FAIL rmid_next_data[%0d]: got %0d, want %0d", i, got_d[i], dval(60 + i));
            end
        end
        n_cmp++;
        if (done_cnt !== 1) begin
            n_err++;
            $display("FAIL rmid_next_done: got %0d, want 1", done_cnt);
        end
        $display("test_reset_mid: next block a=%0d d=%0d done_cyc=%0d", got_a.size(), got_d.size(), done_cyc);
    endtask

    task automatic test_restart_ignored();
        drive_block(10, 3, 20, 5, 0, -1, 1);
        n_cmp++;
        if (got_a.size() !== 3 || got_d.size() !== 5) begin
            n_err++;
            $display("FAIL restart_count: got a=%0d d=%0d, want 3/5", got_a.size(), got_d.size());
        end
        for (int i = 0; i < 3 && i < got_a.size(); i++) begin
            n_cmp++;
            if (got_a[i] !== aval(10 + i)) begin
                n_err++;
                $display("FAIL restart_addr[%0d]: got %0d, want %0d", i, got_a[i], aval(10 + i));
            end
        end
        for (int i = 0; i < 5 && i < got_d.size(); i++) begin
            n_cmp++;
            if (got_d[i] !== dval(20 + i)) begin
                n_err++;
                $display("FAIL restart_data[%0d]: got %0d, want %0d", i, got_d[i], dval(20 + i));
            end
        end
        n_cmp++;
        if (done_cnt !== 1 || done_cyc !== 12) begin
            n_err++;
            $display("FAIL restart_done: got cnt=%0d cyc=%0d, want 1/12", done_cnt, done_cyc);
        end
        $display("test_restart_ignored: done_cnt=%0d done_cyc=%0d", done_cnt, done_cyc);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_len();
        test_wrap();
        test_reset_mid();
        test_restart_ignored();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
